// File: rtl/cpu_mem_sys.sv
// cpu_mem_sys: memory subsystem behind the cpu core.
//
// Holds a single-port word RAM, a memory-mapped trace FIFO that streams
// cpu-written words off chip, and a read-only status register.
//
// Address map:
//   0 .. DEPTH-1  RAM (read/write)
//   16'hFFFE      STATUS (read-only)
//                   {level[7:0], 5'b0, overflow, full, empty}
//   16'hFFFF      TRACE (write-only, pushes into the trace FIFO)
//   all others    unmapped; reads return 0, writes are dropped, both flag bus_err
//
// Optional feature: define MEM_WPROT_EN to write-protect RAM words
// 0 .. WPROT_WORDS-1. Writes there are dropped and flag bus_err.
//
// Ports:
//   clk_i          system clock, rising edge
//   res_i          asynchronous active-low reset
//   mem_addr_i     word address from the cpu
//   mem_data_i     write data from the cpu
//   mem_data_o     registered read data to the cpu (1-cycle latency)
//   mem_ce_ni      chip enable, active-low
//   mem_oe_ni      output enable, active-low
//   mem_we_ni      write enable, active-low (wins over oe)
//   cpu_halt_i     cpu halted indication
//   trace_data_o   trace FIFO head word (0 when empty)
//   trace_valid_o  trace FIFO non-empty
//   trace_ready_i  downstream accepts the head word
//   bus_err_o      one-cycle pulse after an illegal access
//   drain_done_o   registered cpu_halt_i & FIFO empty
module cpu_mem_sys #(
  parameter int DEPTH       = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int WPROT_WORDS = 256
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  input  logic        mem_ce_ni,
  input  logic        mem_oe_ni,
  input  logic        mem_we_ni,
  input  logic        cpu_halt_i,
  output logic [15:0] trace_data_o,
  output logic        trace_valid_o,
  input  logic        trace_ready_i,
  output logic        bus_err_o,
  output logic        drain_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]   ram [DEPTH];
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          overflow;

  logic        is_ram, is_status, is_trace;
  logic        wr_acc, rd_acc;
  logic        wprot_hit;
  logic        ram_we;
  logic        illegal;
  logic        fifo_empty, fifo_full;
  logic        pop, push_req, push_ok, ovf_set;
  logic [15:0] status_word;
  logic [15:0] rd_data;

  assign is_ram    = mem_addr_i < 16'(DEPTH);
  assign is_status = mem_addr_i == 16'hFFFE;
  assign is_trace  = mem_addr_i == 16'hFFFF;

  // write has priority over read when both enables are low
  assign wr_acc = !mem_ce_ni && !mem_we_ni;
  assign rd_acc = !mem_ce_ni && !mem_oe_ni && mem_we_ni;

`ifdef MEM_WPROT_EN
  assign wprot_hit = is_ram && (mem_addr_i < 16'(WPROT_WORDS));
`else
  logic unused_wprot;
  assign unused_wprot = mem_addr_i < 16'(WPROT_WORDS);
  assign wprot_hit    = 1'b0;
`endif

  assign ram_we = wr_acc && is_ram && !wprot_hit;

  // writes may only target RAM or TRACE; reads may only target RAM or STATUS
  assign illegal = (wr_acc && ((!is_ram && !is_trace) || wprot_hit)) ||
                   (rd_acc && !is_ram && !is_status);

  assign fifo_empty = level == '0;
  assign fifo_full  = level == LW'(FIFO_DEPTH);

  assign pop      = !fifo_empty && trace_ready_i;
  assign push_req = wr_acc && is_trace;
  // a full FIFO still accepts a push when the head leaves at the same edge
  assign push_ok  = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;

  assign status_word = {8'(level), 5'b0, overflow, fifo_full, fifo_empty};

  always_comb begin
    rd_data = 16'h0000;
    if (is_ram)
      rd_data = ram[mem_addr_i[AW-1:0]];
    else if (is_status)
      rd_data = status_word;
  end

  assign trace_valid_o = !fifo_empty;
  assign trace_data_o  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];

  // storage arrays carry no reset
  always_ff @(posedge clk_i) begin
    if (ram_we)
      ram[mem_addr_i[AW-1:0]] <= mem_data_i;
    if (push_ok)
      fifo_mem[wr_ptr] <= mem_data_i;
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      mem_data_o   <= 16'h0000;
      bus_err_o    <= 1'b0;
      drain_done_o <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      overflow     <= 1'b0;
    end else begin
      if (rd_acc)
        mem_data_o <= rd_data;
      bus_err_o    <= illegal;
      drain_done_o <= cpu_halt_i && fifo_empty;
      if (push_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
      // a fresh overflow beats the clear-on-read of STATUS
      if (ovf_set)
        overflow <= 1'b1;
      else if (rd_acc && is_status)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_mem_sys.sv
module tb_cpu_mem_sys;

  logic        clk_i;
  logic        res_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_ce_ni;
  logic        mem_oe_ni;
  logic        mem_we_ni;
  logic        cpu_halt_i;
  logic [15:0] trace_data_o;
  logic        trace_valid_o;
  logic        trace_ready_i;
  logic        bus_err_o;
  logic        drain_done_o;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_mem_sys dut (
    .clk_i         (clk_i),
    .res_i         (res_i),
    .mem_addr_i    (mem_addr_i),
    .mem_data_i    (mem_data_i),
    .mem_data_o    (mem_data_o),
    .mem_ce_ni     (mem_ce_ni),
    .mem_oe_ni     (mem_oe_ni),
    .mem_we_ni     (mem_we_ni),
    .cpu_halt_i    (cpu_halt_i),
    .trace_data_o  (trace_data_o),
    .trace_valid_o (trace_valid_o),
    .trace_ready_i (trace_ready_i),
    .bus_err_o     (bus_err_o),
    .drain_done_o  (drain_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    mem_addr_i = a;
    mem_data_i = d;
    mem_ce_ni  = 1'b0;
    mem_oe_ni  = 1'b1;
    mem_we_ni  = 1'b0;
    tick();
    mem_ce_ni  = 1'b1;
    mem_we_ni  = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a);
    mem_addr_i = a;
    mem_ce_ni  = 1'b0;
    mem_oe_ni  = 1'b0;
    mem_we_ni  = 1'b1;
    tick();
    mem_ce_ni  = 1'b1;
    mem_oe_ni  = 1'b1;
  endtask

  task automatic test_reset();
    tests_run++; if (mem_data_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_mem_data: got %h want 0000", mem_data_o); end
    tests_run++; if (trace_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_trace_valid: got %b want 0", trace_valid_o); end
    tests_run++; if (trace_data_o !== 16'h0000) begin tests_failed++; $display("FAIL reset_trace_data: got %h want 0000", trace_data_o); end
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_bus_err: got %b want 0", bus_err_o); end
    tests_run++; if (drain_done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_drain_done: got %b want 0", drain_done_o); end
    @(posedge clk_i); #1;
    res_i = 1'b1;
    tick();
    bus_read(16'hFFFE);
    tests_run++; if (mem_data_o !== 16'h0001) begin tests_failed++; $display("FAIL reset_status: got %h want 0001", mem_data_o); end
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_status_err: got %b want 0", bus_err_o); end
    // clear mem_data_o back to a known zero via an unmapped read, then idle
    bus_read(16'h9000);
    tick();
  endtask

  task automatic test_ram_rw();
    bus_write(16'h0300, 16'hA5A5);
    tests_run++; if (mem_data_o !== 16'h0000) begin tests_failed++; $display("FAIL ram_before_read: got %h want 0000", mem_data_o); end
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ram_write_err: got %b want 0", bus_err_o); end
    bus_read(16'h0300);
    tests_run++; if (mem_data_o !== 16'hA5A5) begin tests_failed++; $display("FAIL ram_readback: got %h want a5a5", mem_data_o); end
    tick();
    tests_run++; if (mem_data_o !== 16'hA5A5) begin tests_failed++; $display("FAIL ram_hold: got %h want a5a5", mem_data_o); end
  endtask

  task automatic test_write_priority();
    mem_addr_i = 16'h0301;
    mem_data_i = 16'h1234;
    mem_ce_ni  = 1'b0;
    mem_oe_ni  = 1'b0;
    mem_we_ni  = 1'b0;
    tick();
    mem_ce_ni  = 1'b1;
    mem_oe_ni  = 1'b1;
    mem_we_ni  = 1'b1;
    tests_run++; if (mem_data_o !== 16'hA5A5) begin tests_failed++; $display("FAIL prio_data_held: got %h want a5a5", mem_data_o); end
    bus_read(16'h0301);
    tests_run++; if (mem_data_o !== 16'h1234) begin tests_failed++; $display("FAIL prio_readback: got %h want 1234", mem_data_o); end
  endtask

  task automatic test_overflow();
    trace_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(16'hFFFF, 16'(i));
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_trace_err: got %b want 0", bus_err_o); end
    tests_run++; if (trace_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_valid: got %b want 1", trace_valid_o); end
    tests_run++; if (trace_data_o !== 16'h0001) begin tests_failed++; $display("FAIL ovf_head: got %h want 0001", trace_data_o); end
    bus_read(16'hFFFE);
    tests_run++; if (mem_data_o !== 16'h0406) begin tests_failed++; $display("FAIL ovf_status1: got %h want 0406", mem_data_o); end
    bus_read(16'hFFFE);
    tests_run++; if (mem_data_o !== 16'h0402) begin tests_failed++; $display("FAIL ovf_status2: got %h want 0402", mem_data_o); end
    trace_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tests_run++; if (trace_data_o !== 16'(i) || trace_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_drain_%0d: got %h valid %b want %h valid 1", i, trace_data_o, trace_valid_o, 16'(i)); end
      tick();
    end
    trace_ready_i = 1'b0;
    tests_run++; if (trace_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_empty: got %b want 0", trace_valid_o); end
  endtask

  task automatic test_full_pop_push();
    logic [15:0] exp_q [4];
    exp_q = '{16'h0011, 16'h0012, 16'h0013, 16'h0014};
    trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(16'hFFFF, 16'h0010 + 16'(i));
    trace_ready_i = 1'b1;
    bus_write(16'hFFFF, 16'h0014);
    trace_ready_i = 1'b0;
    tests_run++; if (trace_data_o !== 16'h0011) begin tests_failed++; $display("FAIL fpp_head: got %h want 0011", trace_data_o); end
    bus_read(16'hFFFE);
    tests_run++; if (mem_data_o !== 16'h0402) begin tests_failed++; $display("FAIL fpp_status: got %h want 0402", mem_data_o); end
    trace_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (trace_data_o !== exp_q[i]) begin tests_failed++; $display("FAIL fpp_drain_%0d: got %h want %h", i, trace_data_o, exp_q[i]); end
      tick();
    end
    trace_ready_i = 1'b0;
    tests_run++; if (trace_valid_o !== 1'b0) begin tests_failed++; $display("FAIL fpp_empty: got %b want 0", trace_valid_o); end
  endtask

  task automatic test_illegal();
    bus_read(16'h8000);
    tests_run++; if (mem_data_o !== 16'h0000) begin tests_failed++; $display("FAIL ill_unmapped_data: got %h want 0000", mem_data_o); end
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_unmapped_err: got %b want 1", bus_err_o); end
    tick();
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_pulse_end: got %b want 0", bus_err_o); end
    bus_write(16'hFFFE, 16'hBEEF);
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_status_wr_err: got %b want 1", bus_err_o); end
    tick();
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_status_wr_end: got %b want 0", bus_err_o); end
    bus_read(16'h0300);
    bus_read(16'hFFFF);
    tests_run++; if (mem_data_o !== 16'h0000) begin tests_failed++; $display("FAIL ill_trace_rd_data: got %h want 0000", mem_data_o); end
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_trace_rd_err: got %b want 1", bus_err_o); end
    bus_write(16'hC000, 16'h0001);
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_b2b_err: got %b want 1", bus_err_o); end
    tests_run++; if (trace_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ill_no_push: got %b want 0", trace_valid_o); end
    tick();
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_b2b_end: got %b want 0", bus_err_o); end
    bus_read(16'h0400);
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL ill_depth_edge: got %b want 1", bus_err_o); end
    bus_read(16'h03FF);
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL ill_last_word: got %b want 0", bus_err_o); end
  endtask

  task automatic test_wprot();
    bus_write(16'h0100, 16'h5A5A);
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL wp_above_err: got %b want 0", bus_err_o); end
    bus_read(16'h0100);
    tests_run++; if (mem_data_o !== 16'h5A5A) begin tests_failed++; $display("FAIL wp_above_data: got %h want 5a5a", mem_data_o); end
    bus_read(16'h0010);
    bus_write(16'h0010, 16'hFFFF);
`ifdef MEM_WPROT_EN
    tests_run++; if (bus_err_o !== 1'b1) begin tests_failed++; $display("FAIL wp_err: got %b want 1", bus_err_o); end
    begin
      logic [15:0] old_val;
      old_val = mem_data_o;
      bus_read(16'h0010);
      tests_run++; if (mem_data_o !== old_val) begin tests_failed++; $display("FAIL wp_data: got %h want %h", mem_data_o, old_val); end
    end
`else
    tests_run++; if (bus_err_o !== 1'b0) begin tests_failed++; $display("FAIL wp_err: got %b want 0", bus_err_o); end
    bus_read(16'h0010);
    tests_run++; if (mem_data_o !== 16'hFFFF) begin tests_failed++; $display("FAIL wp_data: got %h want ffff", mem_data_o); end
`endif
  endtask

  task automatic test_drain();
    trace_ready_i = 1'b0;
    cpu_halt_i    = 1'b0;
    bus_write(16'hFFFF, 16'h0007);
    bus_write(16'hFFFF, 16'h0008);
    cpu_halt_i = 1'b1;
    tick();
    tests_run++; if (drain_done_o !== 1'b0) begin tests_failed++; $display("FAIL drain_queued: got %b want 0", drain_done_o); end
    trace_ready_i = 1'b1;
    tick();
    tests_run++; if (trace_data_o !== 16'h0008 || drain_done_o !== 1'b0) begin tests_failed++; $display("FAIL drain_one_left: got %h done %b want 0008 done 0", trace_data_o, drain_done_o); end
    tick();
    tests_run++; if (trace_valid_o !== 1'b0 || drain_done_o !== 1'b0) begin tests_failed++; $display("FAIL drain_emptied: got valid %b done %b want 0 0", trace_valid_o, drain_done_o); end
    tick();
    tests_run++; if (drain_done_o !== 1'b1) begin tests_failed++; $display("FAIL drain_done_rise: got %b want 1", drain_done_o); end
    cpu_halt_i = 1'b0;
    tick();
    tests_run++; if (drain_done_o !== 1'b0) begin tests_failed++; $display("FAIL drain_done_fall: got %b want 0", drain_done_o); end
    trace_ready_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus_write(16'hFFFF, 16'h00AA);
    tests_run++; if (trace_valid_o !== 1'b1) begin tests_failed++; $display("FAIL mrst_pushed: got %b want 1", trace_valid_o); end
    #2 res_i = 1'b0;
    #1;
    tests_run++; if (trace_valid_o !== 1'b0 || trace_data_o !== 16'h0000 || mem_data_o !== 16'h0000) begin tests_failed++; $display("FAIL mrst_cleared: got valid %b data %h rd %h want 0 0000 0000", trace_valid_o, trace_data_o, mem_data_o); end
    res_i = 1'b1;
    tick();
    bus_read(16'hFFFE);
    tests_run++; if (mem_data_o !== 16'h0001) begin tests_failed++; $display("FAIL mrst_status: got %h want 0001", mem_data_o); end
  endtask

  initial begin
    res_i         = 1'b0;
    mem_addr_i    = 16'h0000;
    mem_data_i    = 16'h0000;
    mem_ce_ni     = 1'b1;
    mem_oe_ni     = 1'b1;
    mem_we_ni     = 1'b1;
    cpu_halt_i    = 1'b0;
    trace_ready_i = 1'b0;
    #12;
    test_reset();
    test_ram_rw();
    test_write_priority();
    test_overflow();
    test_full_pop_push();
    test_illegal();
    test_wprot();
    test_drain();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_mem_sys.md
Name: cpu_mem_sys

Overview:
- Memory subsystem directly downstream of the cpu core; consumes its mem_addr/mem_data/strobe outputs and returns read data on the cpu's mem_data_i.
- Contains a single-port word RAM, a memory-mapped trace FIFO that streams cpu-written words out of the chip, and a status register.
- Used in functional simulation and on silicon. Scan signals are handled at the top level, not here.

Parameters:
- DEPTH, 1024: RAM words, mapped at 0..DEPTH-1; power of two, max 32768.
- FIFO_DEPTH, 4: trace FIFO entries; power of two, 2..128.
- WPROT_WORDS, 256: words at 0..WPROT_WORDS-1 that are write-protected when MEM_WPROT_EN is defined.

Ports:
- clk_i  in  1  system clock; rising edge.
- res_i  in  1  asynchronous, active-low reset.
- mem_addr_i  in  16  word address from cpu mem_addr_o.
- mem_data_i  in  16  write data from cpu mem_data_o.
- mem_data_o  out  16  read data to cpu mem_data_i.
- mem_ce_ni  in  1  chip enable, active-low.
- mem_oe_ni  in  1  output enable, active-low.
- mem_we_ni  in  1  write enable, active-low.
- cpu_halt_i  in  1  cpu halted indication.
- trace_data_o  out  16  FIFO head word.
- trace_valid_o  out  1  FIFO non-empty.
- trace_ready_i  in  1  downstream accepts head.
- bus_err_o  out  1  one-cycle pulse on an illegal access.
- drain_done_o  out  1  cpu halted and trace FIFO empty.

Behaviour:
- All state is clocked on the rising edge of clk_i. res_i low asynchronously clears all state.
- Reset values: mem_data_o=0, trace_valid_o=0, trace_data_o=0, bus_err_o=0, drain_done_o=0, FIFO empty, overflow flag=0. RAM contents are not reset.
- Access decode, sampled at each edge:
  - Idle: ce_n=1, or ce_n=0 with oe_n=1 and we_n=1. No action; mem_data_o holds.
  - Write: ce_n=0, we_n=0. oe_n is ignored; write has priority and mem_data_o is unchanged.
  - Read: ce_n=0, oe_n=0, we_n=1. mem_data_o updates at the same edge, so data is visible from the cycle after the strobe (1-cycle latency). The value holds until the next read.
- Address map:
  - 0..DEPTH-1: RAM.
  - 16'hFFFE: STATUS. Read-only; a write to it is illegal.
  - 16'hFFFF: TRACE. Write-only; a read of it returns 0 and is illegal.
  - All other addresses: unmapped. A read returns 16'h0000, a write is dropped; both are illegal.
- Illegal access: bus_err_o is high for exactly the cycle after the offending edge. Back-to-back illegal accesses keep it high continuously.
- STATUS word:
  - bits 15:8 = FIFO level, zero-extended.
  - bits 7:3 = 0.
  - bit 2 = overflow (sticky).
  - bit 1 = full.
  - bit 0 = empty.
  - The level/flags returned are the values before this edge's push/pop.
  - A STATUS read clears overflow at the same edge. If an overflow occurs at that same edge, set wins.
- Trace FIFO:
  - First-word fall-through: trace_valid_o = not empty, trace_data_o = head (0 when empty).
  - Pop: trace_valid_o & trace_ready_i at an edge.
  - Push: TRACE write.
    - Not full: push is accepted.
    - Full without a pop: push is dropped and overflow is set.
    - Full with a simultaneous pop: push is accepted and the level is unchanged.
    - Empty with a simultaneous ready: the word appears on the next cycle; no same-cycle bypass.
  - Pointers wrap modulo FIFO_DEPTH. The level counter is FIFO_DEPTH+1 valued.
- drain_done_o is registered: cpu_halt_i & empty, sampled each edge.
- Reset asserted mid-transfer: FIFO contents are lost. A RAM write at the reset edge is not guaranteed.

Optional Feature:
- Macro MEM_WPROT_EN.
- When defined: writes to addresses below WPROT_WORDS are dropped, RAM is unchanged, and bus_err_o pulses. Reads of those addresses are normal.
- When undefined: the WPROT_WORDS parameter exists but is ignored, and the whole RAM is writable.

Test Plan:
- Reset, then write 16'hA5A5 to address 0x0300, then read 0x0300 -> mem_data_o=16'hA5A5 one cycle after the read strobe; mem_data_o is 0 before the read.
- Strobe with ce_n=0, oe_n=0, we_n=0 to address 0x0301 with data 16'h1234 -> RAM[0x301]=16'h1234 and mem_data_o unchanged.
- Five TRACE writes 1,2,3,4,5 with trace_ready_i=0, then read STATUS -> 16'h0406; a second STATUS read -> 16'h0402; draining yields 1,2,3,4.
- FIFO full plus a TRACE write while trace_ready_i=1 -> level stays 4, no overflow, and the new word is the last one out.
- Read 0x8000, then write 0xFFFE -> read returns 0 and bus_err_o pulses 1 cycle for each access.
- With MEM_WPROT_EN: write 16'hFFFF to address 0x0010 -> bus_err_o pulses and a readback returns the old value. Without the macro the write succeeds.
- Assert cpu_halt_i with 2 entries queued, then set trace_ready_i=1 -> drain_done_o rises 1 cycle after the FIFO empties.
